// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the pipelined ARM
// core. Holds the fetch PC, selects the next PC (sequential, execute-stage
// branch target or writeback PC write), presents the fetch address to
// instruction memory and captures the returned word into the decode register.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous reset, active-low (0 = reset asserted)
//   StallF        hold PCF (from hazard unit)
//   StallD        hold the IF/ID register
//   FlashD        flush the IF/ID register to a bubble
//   BranchTakenE  execute-stage branch taken, redirect fetch to ALUResultE
//   PCSrcW        writeback writes PC, redirect fetch to ResultW
//   ALUResultE    branch target from execute
//   ResultW       PC value from writeback
//   imem_addr     fetch address to instruction memory (= PCF)
//   imem_req      fetch request, high whenever reset is deasserted
//   imem_rdy      imem_rdata is valid this cycle for imem_addr
//   imem_rdata    instruction word returned by instruction memory
//   PCF           current fetch PC
//   InstrD        instruction presented to decode
//   PCPlus8D      architectural PC read value for InstrD (its fetch PC + 8)
//   ValidD        InstrD is a real instruction (0 for bubbles)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000  // MOV R0,R0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlashD,
  input  logic        BranchTakenE,
  input  logic        PCSrcW,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] ResultW,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD
);

  // -------------------------------------------------------------------------
  // Fetch PC
  // -------------------------------------------------------------------------
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic        redirect;
  logic        pc_en;
  logic        fetch_ok;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;
  assign redirect = PCSrcW | BranchTakenE;

  // A redirect always loads, even while fetch is stalled or memory is not
  // ready: the wrong-path word in flight is simply never captured.
  assign pc_en = redirect | (imem_rdy & ~StallF);

  // Word captured this cycle only if memory delivered it, fetch is not held
  // and the fetch address is not being discarded by a redirect.
  assign fetch_ok = imem_rdy & ~StallF & ~BranchTakenE & ~PCSrcW;

  always_comb begin
    pc_d = pc_q;
    if (PCSrcW) begin
      pc_d = ResultW;
    end else if (BranchTakenE) begin
      pc_d = ALUResultE;
    end else if (pc_en) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (pc_en) begin
      pc_q <= pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // IF/ID register
  // -------------------------------------------------------------------------
  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic [31:0] pc8_q;
  logic [31:0] pc8_d;
  logic        valid_q;
  logic        valid_d;

  // Flush beats stall; a stall holds; otherwise a bubble is loaded whenever
  // no word was fetched, so a held PC is never issued twice.
  always_comb begin
    instr_d = instr_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    if (FlashD) begin
      instr_d = NOP_INSTR;
      pc8_d   = 32'd0;
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (fetch_ok) begin
        instr_d = imem_rdata;
        pc8_d   = pc_plus8;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        pc8_d   = 32'd0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_INSTR;
      pc8_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem_req  = reset;
  assign imem_addr = pc_q;
  assign PCF       = pc_q;
  assign InstrD    = instr_q;
  assign PCPlus8D  = pc8_q;
  assign ValidD    = valid_q;

endmodule
